// File: rtl/frame_sched.sv
// Line-render scheduler: issues one render request per visible-line trigger and arbitrates host access during vblank.
// Optional saturating drop counter enabled by FRAME_SCHED_OVERRUN_CNT_EN.
module frame_sched #(
  parameter int H_VIEW = 640,
  parameter int V_VIEW = 480,
  parameter int V_MAX  = 524
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic       line_req,
  output logic [9:0] line_num,
  input  logic       line_ack,
  input  logic       line_done,
  input  logic       host_req,
  output logic       host_gnt,
  output logic       overrun,
  output logic [7:0] overrun_count,
  output logic [1:0] dbg_state
);

  // Handshake: line_req/line_num are held stable until line_ack is sampled high
  // in the REQ state; the request is consumed on that edge. line_done is a
  // single-cycle completion pulse honoured only in BUSY.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_HOST = 2'd3
  } state_t;

  localparam logic [9:0] H_TRIG    = 10'(H_VIEW);
  localparam logic [9:0] V_VIS_END = 10'(V_VIEW);
  localparam logic [9:0] V_LAST    = 10'(V_MAX);
  localparam logic [9:0] V_PRE     = 10'(V_VIEW - 1);

  state_t     state_q, state_d;
  logic       line_req_q, line_req_d;
  logic [9:0] line_num_q, line_num_d;
  logic       host_gnt_q, host_gnt_d;
  logic       overrun_q, overrun_d;

  logic       trigger;
  logic [9:0] target;
  logic       host_ok;

  always_comb begin
    trigger = (hpos == H_TRIG) && ((vpos < V_PRE) || (vpos == V_LAST));
    target  = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    // Host window is vblank only, closing before the line-0 prefetch line.
    host_ok = host_req && (vpos >= V_VIS_END) && (vpos < V_LAST);
  end

  always_comb begin
    state_d    = state_q;
    line_req_d = line_req_q;
    line_num_d = line_num_q;
    host_gnt_d = host_gnt_q;
    overrun_d  = trigger && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d    = S_REQ;
          line_req_d = 1'b1;
          line_num_d = target;
        end else if (host_ok) begin
          state_d    = S_HOST;
          host_gnt_d = 1'b1;
        end
      end
      S_REQ: begin
        if (line_ack) begin
          state_d    = S_BUSY;
          line_req_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (line_done) state_d = S_IDLE;
      end
      S_HOST: begin
        if (!host_req || (vpos == V_LAST)) begin
          state_d    = S_IDLE;
          host_gnt_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      line_req_q <= 1'b0;
      line_num_q <= 10'd0;
      host_gnt_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_req_q <= line_req_d;
      line_num_q <= line_num_d;
      host_gnt_q <= host_gnt_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ovr_cnt_q <= 8'd0;
    else          ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_count = ovr_cnt_q;
`else
  assign overrun_count = 8'd0;
`endif

  assign line_req  = line_req_q;
  assign line_num  = line_num_q;
  assign host_gnt  = host_gnt_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: directed scenarios plus randomized traffic against a
// resource-ownership model; drop-counter expectations follow FRAME_SCHED_OVERRUN_CNT_EN.
module tb_frame_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hpos, vpos;
  logic       line_req;
  logic [9:0] line_num;
  logic       line_ack, line_done, host_req;
  logic       host_gnt, overrun;
  logic [7:0] overrun_count;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  frame_sched dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
    .line_req(line_req), .line_num(line_num), .line_ack(line_ack),
    .line_done(line_done), .host_req(host_req), .host_gnt(host_gnt),
    .overrun(overrun), .overrun_count(overrun_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the engine / shared state rather than an FSM encoding.
  bit   model_valid = 0;
  bit   m_request_open, m_engine_rendering, m_host_owns;
  int   m_line, m_drops;
  bit   m_drop_pulse;
  logic [9:0] exp_q[$];

  function automatic int cnt_expect(input int drops);
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    return (drops > 255) ? 255 : drops;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      model_valid = 1;
      m_request_open = 0; m_engine_rendering = 0; m_host_owns = 0;
      m_line = 0; m_drops = 0; m_drop_pulse = 0;
      exp_q.delete();
    end else if (model_valid) begin
      int  h, v;
      bit  fire, occupied;
      h = int'(hpos); v = int'(vpos);
      fire = (h == 640) && (v < 479 || v == 524);
      occupied = m_request_open || m_engine_rendering || m_host_owns;
      m_drop_pulse = fire && occupied;
      if (m_drop_pulse) m_drops++;
      if (!occupied) begin
        if (fire) begin
          m_request_open = 1;
          m_line = (v == 524) ? 0 : v + 1;
          exp_q.push_back(10'(m_line));
        end else if (host_req && v >= 480 && v < 524) begin
          m_host_owns = 1;
        end
      end else if (m_request_open) begin
        if (line_ack) begin m_request_open = 0; m_engine_rendering = 1; end
      end else if (m_engine_rendering) begin
        if (line_done) m_engine_rendering = 0;
      end else if (!host_req || v == 524) begin
        m_host_owns = 0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (model_valid) begin
      check("line_req", int'(line_req), int'(m_request_open));
      check("line_num", int'(line_num), m_line);
      check("host_gnt", int'(host_gnt), int'(m_host_owns));
      check("overrun", int'(overrun), int'(m_drop_pulse));
      check("overrun_count", int'(overrun_count), cnt_expect(m_drops));
      if (line_req === 1'b1 && prev_req === 1'b0) begin
        if (exp_q.size() == 0) check("req_unexpected", 1, 0);
        else check("req_line", int'(line_num), int'(exp_q.pop_front()));
      end
    end
    prev_req = line_req;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int h, input int v);
    hpos = 10'(h); vpos = 10'(v);
  endtask

  task automatic finish_line();
    drive(0, 100);
    line_ack = 1'b1; step(); line_ack = 1'b0;
    line_done = 1'b1; step(); line_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; hpos = '0; vpos = '0;
    line_ack = 0; line_done = 0; host_req = 0;
    step(); step();
    check("rst_line_req", int'(line_req), 0);
    check("rst_line_num", int'(line_num), 0);
    check("rst_host_gnt", int'(host_gnt), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_count", int'(overrun_count), 0);
    reset_n = 1'b1; step();

    // Trigger at line 10, ack in third request cycle
    drive(640, 10); step();
    drive(0, 10);
    check("d31_req", int'(line_req), 1);
    check("d31_num", int'(line_num), 11);
    step(); check("d31_hold2", int'(line_req), 1);
    line_ack = 1'b1; step(); line_ack = 1'b0;
    check("d31_drop", int'(line_req), 0);
    line_done = 1'b1; step(); line_done = 1'b0;

    // Wrap to line 0; no request off the last visible line
    drive(640, 524); step(); drive(0, 524);
    check("d32_num0", int'(line_num), 0);
    check("d32_req0", int'(line_req), 1);
    finish_line();
    drive(640, 479); step(); drive(0, 479);
    check("d32_noreq", int'(line_req), 0);

    // Drop while busy, then saturate
    drive(640, 20); step(); drive(0, 20);
    line_ack = 1'b1; step(); line_ack = 1'b0;
    drive(640, 30); step(); drive(0, 30);
    check("d33_ovr", int'(overrun), 1);
    check("d33_cnt1", int'(overrun_count), cnt_expect(1));
    check("d33_noreq", int'(line_req), 0);
    step(); check("d33_ovr_off", int'(overrun), 0);
    drive(640, 40);
    for (int i = 0; i < 299; i++) step();
    drive(0, 40); step();
    check("d33_sat", int'(overrun_count), cnt_expect(300));
    line_done = 1'b1; step(); line_done = 1'b0;

    // Host window
    host_req = 1'b1; drive(0, 478); step();
    check("d34_nogrant", int'(host_gnt), 0);
    drive(0, 480); step();
    check("d34_grant", int'(host_gnt), 1);
    drive(0, 524); step();
    check("d34_revoke", int'(host_gnt), 0);
    drive(640, 524); step(); drive(0, 524);
    check("d34_line0_req", int'(line_req), 1);
    check("d34_line0_num", int'(line_num), 0);
    host_req = 1'b0;
    finish_line();

    // Reset mid-handshake, stray done ignored
    drive(640, 5); step(); drive(0, 5);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    check("d35_req", int'(line_req), 0);
    check("d35_num", int'(line_num), 0);
    check("d35_cnt", int'(overrun_count), 0);
    line_done = 1'b1; step(); line_done = 1'b0;
    check("d35_idle", int'(dbg_state), 0);
    drive(640, 7); step(); drive(0, 7);
    check("d35_newreq", int'(line_num), 8);
    finish_line();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int v;
      case ($urandom_range(0, 5))
        0:       v = 524;
        1:       v = $urandom_range(476, 482);
        2:       v = $urandom_range(480, 523);
        default: v = $urandom_range(0, 524);
      endcase
      drive(($urandom_range(0, 2) == 0) ? 640 : $urandom_range(0, 799), v);
      line_ack  = ($urandom_range(0, 3) == 0);
      line_done = ($urandom_range(0, 4) == 0);
      host_req  = ($urandom_range(0, 1) == 0);
      reset_n   = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
